// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM state
// numbers, supported opcodes, ALU/mux select encodings and the
// control-word struct driven by the output decoder. The ALU-control
// block imports the same package.
package mips_pkg;

  // FSM states (4-bit; 12..15 unused)
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADDR = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_ADDIEX  = 4'd10;
  localparam logic [3:0] S_ADDIWB  = 4'd11;

  // Opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // aluOp
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // aluSrcB
  localparam logic [1:0] SRCB_B        = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_SEXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

  // pcSource
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       irWrite;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       illegalOp;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/control_output_decoder.sv
// Combinational state -> control-word map for the multicycle control FSM.
// Ports:
//   state_i   current FSM state
//   opcode_i  IR opcode, used only to flag an illegal opcode in DECODE
//   ctrl_o    control word (pcWrite/pcWriteCond are ungated here)
module control_output_decoder
  import mips_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.memRead  = 1'b1;
        ctrl_o.irWrite  = 1'b1;
        ctrl_o.aluSrcB  = SRCB_FOUR;
        ctrl_o.aluOp    = ALUOP_ADD;
        ctrl_o.pcWrite  = 1'b1;
        ctrl_o.pcSource = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl_o.aluSrcB   = SRCB_SEXT_SH2;
        ctrl_o.aluOp     = ALUOP_ADD;
        ctrl_o.illegalOp = ~is_legal_op(opcode_i);
      end
      S_MEMADDR, S_ADDIEX: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_SEXT;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.memRead = 1'b1;
        ctrl_o.iorD    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.memToReg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.memWrite = 1'b1;
        ctrl_o.iorD     = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_B;
        ctrl_o.aluOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.regDst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.aluSrcA     = 1'b1;
        ctrl_o.aluOp       = ALUOP_SUB;
        ctrl_o.pcWriteCond = 1'b1;
        ctrl_o.pcSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pcWrite  = 1'b1;
        ctrl_o.pcSource = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        ctrl_o.regWrite = 1'b1;
      end
      default: ctrl_o = '0; // unused encodings drive nothing
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main Moore control FSM of the multicycle MIPS datapath.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   opcode, zero      IR opcode and ALU zero flag
//   pcEnable          PC enable = pcWrite | (pcWriteCond & zero)
//   irWrite .. pcSource  datapath register enables, mux selects, strobes
//   illegalOp         one-cycle flag in DECODE for an unsupported opcode
//   state             current state, for debug
// While RST is high every output is forced to 0 so that an aborted
// instruction cannot produce a write in the reset cycle.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pcEnable,
  output logic       irWrite,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       illegalOp,
  output logic [3:0] state
);

  logic [3:0] state_q, state_d;
  ctrl_t      ctrl;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      // opcode is held stable by the IR, so anything but lw/sw here
      // means a corrupted IR; fall back to FETCH.
      S_MEMADDR: begin
        if      (opcode == OP_LW) state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  control_output_decoder u_dec (
    .state_i  (state_q),
    .opcode_i (opcode),
    .ctrl_o   (ctrl)
  );

  // Output logic: reset gating and the PC enable merge
  always_comb begin
    pcEnable  = 1'b0;
    irWrite   = 1'b0;
    iorD      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    memToReg  = 1'b0;
    regDst    = 1'b0;
    regWrite  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    pcSource  = 2'b00;
    illegalOp = 1'b0;
    state     = 4'd0;
    if (!RST) begin
      pcEnable  = ctrl.pcWrite | (ctrl.pcWriteCond & zero);
      irWrite   = ctrl.irWrite;
      iorD      = ctrl.iorD;
      memRead   = ctrl.memRead;
      memWrite  = ctrl.memWrite;
      memToReg  = ctrl.memToReg;
      regDst    = ctrl.regDst;
      regWrite  = ctrl.regWrite;
      aluSrcA   = ctrl.aluSrcA;
      aluSrcB   = ctrl.aluSrcB;
      aluOp     = ctrl.aluOp;
      pcSource  = ctrl.pcSource;
      illegalOp = ctrl.illegalOp;
      state     = state_q;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Each step advances one clock
// and checks the state and the full output word against hand-built
// expectations taken from the per-state control table.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] opcode;
  logic       zero;
  logic       pcEnable, irWrite, iorD, memRead, memWrite, memToReg;
  logic       regDst, regWrite, aluSrcA, illegalOp;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;
  int mw_cnt = 0;

  always #5 CLK = ~CLK;

  multicycle_control dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero),
    .pcEnable(pcEnable), .irWrite(irWrite), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
    .regDst(regDst), .regWrite(regWrite), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
    .illegalOp(illegalOp), .state(state)
  );

  // {pcEnable,irWrite,iorD,memRead,memWrite,memToReg,regDst,regWrite,
  //  aluSrcA,aluSrcB,aluOp,pcSource,illegalOp}
  wire [14:0] word = {pcEnable, irWrite, iorD, memRead, memWrite, memToReg,
                      regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
                      illegalOp};

  function automatic logic [14:0] ow(
    input logic pe, input logic ir, input logic iod, input logic mr,
    input logic mw, input logic m2r, input logic rd, input logic rw,
    input logic sa, input logic [1:0] sb, input logic [1:0] op,
    input logic [1:0] ps, input logic ill);
    return {pe, ir, iod, mr, mw, m2r, rd, rw, sa, sb, op, ps, ill};
  endfunction

  logic [14:0] W_FETCH, W_DEC, W_DEC_ILL, W_MADDR, W_MRD, W_MWB, W_MWR;
  logic [14:0] W_EXEC, W_ALUWB, W_BR_T, W_BR_F, W_JUMP, W_AIWB;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
    if (memWrite === 1'b1) mw_cnt++;
  endtask

  task automatic step_chk(input string tag, input logic [3:0] st,
                          input logic [14:0] w);
    step();
    chk({tag, ".state"}, {28'd0, state}, {28'd0, st});
    chk({tag, ".word"},  {17'd0, word},  {17'd0, w});
  endtask

  initial begin
    W_FETCH   = ow(1,1,0,1,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    W_DEC     = ow(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    W_DEC_ILL = ow(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
    W_MADDR   = ow(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    W_MRD     = ow(0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    W_MWB     = ow(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
    W_MWR     = ow(0,0,1,0,1,0,0,0,0,2'b00,2'b00,2'b00,0);
    W_EXEC    = ow(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
    W_ALUWB   = ow(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
    W_BR_T    = ow(1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    W_BR_F    = ow(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    W_JUMP    = ow(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
    W_AIWB    = ow(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);

    // Reset for two cycles
    RST = 1'b1; opcode = 6'b100011; zero = 1'b1;
    step(); chk("rst1.word", {17'd0, word}, 32'd0);
    step(); chk("rst2.word", {17'd0, word}, 32'd0);
    chk("rst2.state", {28'd0, state}, 32'd0);
    RST = 1'b0; zero = 1'b0; #1;
    chk("fetch0.state", {28'd0, state}, 32'd0);
    chk("fetch0.word", {17'd0, word}, {17'd0, W_FETCH});

    // lw: 0,1,2,3,4,0
    opcode = 6'b100011;
    step_chk("lw.dec", 4'd1, W_DEC);
    step_chk("lw.maddr", 4'd2, W_MADDR);
    step_chk("lw.mrd", 4'd3, W_MRD);
    step_chk("lw.mwb", 4'd4, W_MWB);
    step_chk("lw.fetch", 4'd0, W_FETCH);

    // beq taken
    opcode = 6'b000100; zero = 1'b1;
    step_chk("beqT.dec", 4'd1, W_DEC);
    step_chk("beqT.br", 4'd8, W_BR_T);
    step_chk("beqT.fetch", 4'd0, W_FETCH);

    // beq not taken
    zero = 1'b0;
    step_chk("beqF.dec", 4'd1, W_DEC);
    step_chk("beqF.br", 4'd8, W_BR_F);
    step_chk("beqF.fetch", 4'd0, W_FETCH);

    // sw then R-type back to back, 8 cycles
    opcode = 6'b101011; mw_cnt = 0;
    step_chk("sw.dec", 4'd1, W_DEC);
    step_chk("sw.maddr", 4'd2, W_MADDR);
    step_chk("sw.mwr", 4'd5, W_MWR);
    step_chk("sw.fetch", 4'd0, W_FETCH);
    opcode = 6'b000000;
    step_chk("r.dec", 4'd1, W_DEC);
    step_chk("r.exec", 4'd6, W_EXEC);
    step_chk("r.aluwb", 4'd7, W_ALUWB);
    step_chk("r.fetch", 4'd0, W_FETCH);
    chk("sw.mw_pulses", mw_cnt, 32'd1);

    // j
    opcode = 6'b000010;
    step_chk("j.dec", 4'd1, W_DEC);
    step_chk("j.jump", 4'd9, W_JUMP);
    step_chk("j.fetch", 4'd0, W_FETCH);

    // addi
    opcode = 6'b001000;
    step_chk("addi.dec", 4'd1, W_DEC);
    step_chk("addi.ex", 4'd10, W_MADDR);
    step_chk("addi.wb", 4'd11, W_AIWB);
    step_chk("addi.fetch", 4'd0, W_FETCH);

    // illegal opcode
    opcode = 6'b111111;
    step_chk("ill.dec", 4'd1, W_DEC_ILL);
    step_chk("ill.fetch", 4'd0, W_FETCH);

    // reset during MEMWR of sw
    opcode = 6'b101011;
    step_chk("swr.dec", 4'd1, W_DEC);
    step_chk("swr.maddr", 4'd2, W_MADDR);
    step_chk("swr.mwr", 4'd5, W_MWR);
    RST = 1'b1; #1;
    chk("swr.rst.memWrite", {31'd0, memWrite}, 32'd0);
    chk("swr.rst.word", {17'd0, word}, 32'd0);
    step();
    RST = 1'b0; #1;
    chk("swr.after.state", {28'd0, state}, 32'd0);
    chk("swr.after.word", {17'd0, word}, {17'd0, W_FETCH});

    // reset during MEMWB of lw
    opcode = 6'b100011;
    step_chk("lwr.dec", 4'd1, W_DEC);
    step_chk("lwr.maddr", 4'd2, W_MADDR);
    step_chk("lwr.mrd", 4'd3, W_MRD);
    step_chk("lwr.mwb", 4'd4, W_MWB);
    RST = 1'b1; #1;
    chk("lwr.rst.regWrite", {31'd0, regWrite}, 32'd0);
    chk("lwr.rst.word", {17'd0, word}, 32'd0);
    step();
    RST = 1'b0; #1;
    chk("lwr.after.state", {28'd0, state}, 32'd0);
    chk("lwr.after.word", {17'd0, word}, {17'd0, W_FETCH});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the write enables of the datapath's enabled 32-bit registers (PC, IR, MDR, A/B, ALUOut) plus the mux selects and the memory and register-file strobes. It sits directly upstream of those registers: its `pcEnable` and `irWrite` outputs are their `control` inputs.

## Interface
Parameters:
- none; encodings come from the shared package.

Ports:
- `CLK`  in  1  single clock, rising edge
- `RST`  in  1  synchronous, active-high reset
- `opcode`  in  6  IR[31:26], valid from the cycle after FETCH
- `zero`  in  1  ALU zero flag, sampled in BRANCH
- `pcEnable`  out  1  PC register enable = pcWrite | (pcWriteCond & zero)
- `irWrite`  out  1  IR register enable
- `iorD`  out  1  memory address select (0 = PC, 1 = ALUOut)
- `memRead` / `memWrite`  out  1 each  memory strobes
- `memToReg`  out  1  write-back data select (0 = ALUOut, 1 = MDR)
- `regDst`  out  1  destination select (0 = rt, 1 = rd)
- `regWrite`  out  1  register-file write
- `aluSrcA`  out  1  ALU A select (0 = PC, 1 = A)
- `aluSrcB`  out  2  ALU B select (00 = B, 01 = 4, 10 = signext, 11 = signext<<2)
- `aluOp`  out  2  00 = add, 01 = sub, 10 = funct-decoded
- `pcSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `illegalOp`  out  1  one-cycle flag for an unsupported opcode
- `state`  out  4  current state, for debug

## Operation
- Moore FSM. The state register updates on rising `CLK`. Outputs are a pure decode of the state, except `pcEnable`, which also depends on `zero`.
- States and transitions:
  - FETCH (0) → DECODE
  - DECODE (1) → by opcode:
    - R-type 000000 → EXEC
    - lw 100011 / sw 101011 → MEMADDR
    - beq 000100 → BRANCH
    - j 000010 → JUMP
    - addi 001000 → ADDIEX
    - any other opcode → FETCH
  - MEMADDR (2) → MEMRD if lw, MEMWR if sw
  - MEMRD (3) → MEMWB (4) → FETCH
  - MEMWR (5) → FETCH
  - EXEC (6) → ALUWB (7) → FETCH
  - BRANCH (8) → FETCH
  - JUMP (9) → FETCH
  - ADDIEX (10) → ADDIWB (11) → FETCH
- Asserted outputs per state (every output not listed is 0):
  - FETCH: memRead, irWrite, aluSrcB=01, aluOp=00, pcWrite, pcSource=00
  - DECODE: aluSrcB=11, aluOp=00
  - MEMADDR / ADDIEX: aluSrcA, aluSrcB=10, aluOp=00
  - MEMRD: memRead, iorD
  - MEMWB: regWrite, memToReg, regDst=0
  - MEMWR: memWrite, iorD
  - EXEC: aluSrcA, aluSrcB=00, aluOp=10
  - ALUWB: regWrite, regDst=1
  - BRANCH: aluSrcA, aluOp=01, pcWriteCond, pcSource=01
  - JUMP: pcWrite, pcSource=10
  - ADDIWB: regWrite, regDst=0
  - DECODE with an illegal opcode: illegalOp=1
- States 12–15 are unreachable. If entered, the FSM goes to FETCH with all outputs 0.

## Timing
- Reset:
  - `RST` high at a rising edge → state = FETCH.
  - While `RST` is high, every output is forced to 0 combinationally, including `pcEnable`, `irWrite`, `memWrite` and `regWrite`.
  - `state` reads 0 after the edge.
- Reset mid-instruction aborts it. No partial memory or register write occurs after the reset edge.
- First instruction: the first FETCH after `RST` deasserts issues a fetch in that cycle.
- Latency in cycles, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- `opcode` is sampled only in DECODE and MEMADDR. It must be stable from the edge that ends FETCH, because the IR latches on that edge.
- `zero` is used only in BRANCH, combinationally. `pcEnable` is 0 in BRANCH when `zero` = 0.
- No handshakes or stalls. Memory is single-cycle.

## Structure
- Shared package `mips_pkg`:
  - state localparams (4-bit)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - aluOp, aluSrcB and pcSource encodings
  - the same package serves the ALU-control block
- One sub-module is natural: `control_output_decoder`, a combinational map from state to the control-word outputs. The top module keeps the state register, next-state logic, reset gating and `pcEnable` OR.

## Test plan
- `RST` high for 2 cycles, then low → all outputs 0 during reset; next cycle state=0, memRead=1, irWrite=1, pcEnable=1.
- opcode=100011 (lw) → states 0,1,2,3,4,0. memRead+iorD in state 3; regWrite+memToReg in state 4. Exactly 5 cycles.
- opcode=000100 (beq):
  - with zero=1 → pcEnable=1 and pcSource=01 in BRANCH
  - with zero=0 → pcEnable=0
  - returns to FETCH after 3 cycles either way
- opcode=101011 (sw), then 000000 (R-type), back-to-back → memWrite pulses exactly once; regWrite=1, regDst=1 only in ALUWB; 8 cycles total.
- opcode=111111 → illegalOp=1 for one cycle in DECODE, then FETCH; no regWrite or memWrite ever asserted.
- `RST` asserted in MEMWR (sw) and in MEMWB (lw) → memWrite and regWrite are 0 in that cycle; state=0 after the edge.
